switches_mmio: RTL

- Memory-mapped input peripheral for the 16 board slide switches.
- Sits on the same data-memory bus as the LED peripheral, at the neighbouring addresses. The CPU reads switch state here and writes it to the LEDs.
- Synchronises and debounces the raw pins, holds a stable 16-bit value, and keeps a sticky "changed" flag that software can poll and clear.

---
 rtl/switches_mmio_pkg.sv | 18 +
 rtl/switches_mmio_sw_debouncer.sv | 60 ++++++
 rtl/switches_mmio.sv | 65 ++++++
 3 files changed

// File: rtl/switches_mmio_pkg.sv
// rtl/switches_mmio_pkg.sv - shared data-bus memory map for the board peripherals
package switches_mmio_pkg;

    typedef logic [29:0] word_addr_t;

    localparam word_addr_t LED_ADDR  = 30'h00000004;
    localparam word_addr_t SW_ADDR   = 30'h00000005;
    localparam word_addr_t STAT_ADDR = 30'h00000006;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // True when a bus strobe targets the given word address
    function automatic logic addr_hit(input logic strobe, input word_addr_t addr,
                                      input word_addr_t target);
        return strobe && (addr == target);
    endfunction

endpackage

// File: rtl/switches_mmio_sw_debouncer.sv
// rtl/switches_mmio_sw_debouncer.sv - two-flop synchroniser plus counting debouncer
module sw_debouncer
    import switches_mmio_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] stable_out,
    output logic             update_pulse
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_candidate;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt;
    logic             w_same;
    logic             w_load;

    assign w_same = (r_sync2 == r_candidate);
    assign w_load = w_same && (r_cnt == CNT_MAX);

    // Plain flop chain into the clock domain; nothing between the stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any difference restarts the count; the counter saturates once the value is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_candidate <= '0;
            r_cnt       <= '0;
            r_stable    <= '0;
        end else if (!w_same) begin
            r_candidate <= r_sync2;
            r_cnt       <= '0;
        end else if (w_load) begin
            r_stable <= r_candidate;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Same-edge indication so the flag is set on the edge stable actually changes
    assign update_pulse = w_load && (r_candidate != r_stable);
    assign stable_out   = r_stable;

endmodule

// File: rtl/switches_mmio.sv
// rtl/switches_mmio.sv - memory-mapped debounced slide-switch input with sticky change flag
module switches_mmio
    import switches_mmio_pkg::*;
#(
    parameter logic [29:0] SW_ADDR         = switches_mmio_pkg::SW_ADDR,
    parameter logic [29:0] STAT_ADDR       = switches_mmio_pkg::STAT_ADDR,
    parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] writeData,
    input  logic        writeEnable,
    input  logic        readEnable,
    input  logic [29:0] memAddress,
    input  logic [15:0] switches,
    output logic [31:0] readData,
    output logic        swChanged
);

    logic [15:0] w_stable;
    logic        w_update;
    logic        w_clear;
    logic        r_flag;
    logic        w_unused_wdata;

    // Status writes only ever clear the flag, so the data bits carry no meaning
    assign w_unused_wdata = &{1'b0, writeData};

    sw_debouncer #(
        .WIDTH           (16),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .rst          (rst),
        .async_in     (switches),
        .stable_out   (w_stable),
        .update_pulse (w_update)
    );

    assign w_clear = addr_hit(writeEnable, memAddress, STAT_ADDR);

    // Sticky change flag; a new change beats a simultaneous clear so no event is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= 1'b0;
        end else if (w_update) begin
            r_flag <= 1'b1;
        end else if (w_clear) begin
            r_flag <= 1'b0;
        end
    end

    // Zero-wait-state read mux; reads never disturb state
    always_comb begin
        readData = 32'd0;
        if (addr_hit(readEnable, memAddress, SW_ADDR)) begin
            readData = {16'd0, w_stable};
        end else if (addr_hit(readEnable, memAddress, STAT_ADDR)) begin
            readData = {31'd0, r_flag};
        end
    end

    assign swChanged = r_flag;

endmodule
